// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard/forwarding control.
// Forward select encoding, sequencer states, scoreboard entry.
package hazard_pkg;

    localparam int XZR_IDX = 31;
    // Scoreboard rd field width; must be >= REG_AW of the top.
    localparam int SB_RD_W = 8;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_ALU_E = 2'd1,
        FWD_MEM_M = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_LD_STALL = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               regwrite;
        logic               memread;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward select and load-use match for the ID stage.
// Ports: src_i/use_i (ID source), sb_e_i/sb_m_i (scoreboard), sel_o, load_hit_o.
module fwd_select #(
    parameter int REG_AW  = 5,
    parameter int XZR_IDX = hazard_pkg::XZR_IDX
) (
    input  logic [REG_AW-1:0]     src_i,
    input  logic                  use_i,
    input  hazard_pkg::sb_entry_t sb_e_i,
    input  hazard_pkg::sb_entry_t sb_m_i,
    output hazard_pkg::fwd_sel_t  sel_o,
    output logic                  load_hit_o
);
    import hazard_pkg::*;

    logic [SB_RD_W-1:0] src_w;
    logic               live;
    logic               e_match;
    logic               m_match;
    logic               unused_m;

    assign src_w = SB_RD_W'(src_i);
    // The zero register is never produced by anyone, so it never matches.
    assign live  = use_i && (src_w != SB_RD_W'(XZR_IDX));

    assign e_match = live && sb_e_i.valid && (sb_e_i.rd == src_w);
    assign m_match = live && sb_m_i.valid && (sb_m_i.rd == src_w);

    // A load in M is already forwardable, only E matters for load-use.
    assign unused_m = sb_m_i.memread;

    always_comb begin
        sel_o = FWD_REG;
        if (e_match && sb_e_i.regwrite) begin
            sel_o = FWD_ALU_E;
        end else if (m_match && sb_m_i.regwrite) begin
            sel_o = FWD_MEM_M;
        end
    end

    assign load_hit_o = e_match && sb_e_i.memread;

endmodule

// File: rtl/hazard_control_unit.sv
// Decode-stage hazard sequencer: EX/MEM scoreboard, forward selects,
// load-use stall, taken-branch squash and data-memory busy freeze.
// Ports: ID inputs (valid_d, Aa, Ab, use_*_d, RdD, RegWriteD, MemReadD,
//   BrTakenD), mem_busy; outputs ForwardA/B, StallF/D, FlushD/E.
// HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt counters.
module hazard_control_unit #(
    parameter int REG_AW  = 5,
    parameter int XZR_IDX = 31
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int PERF_CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] Aa,
    input  logic [REG_AW-1:0] Ab,
    input  logic              use_a_d,
    input  logic              use_b_d,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              MemReadD,
    input  logic              BrTakenD,
    input  logic              mem_busy,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);
    import hazard_pkg::*;

    sb_entry_t e_q, e_d, m_q;
    hz_state_t state_q, state_d;
    fwd_sel_t  fwd_a, fwd_b;
    logic      ld_a, ld_b;
    logic      hazard;
    logic      ld_stall;

    fwd_select #(.REG_AW(REG_AW), .XZR_IDX(XZR_IDX)) u_fwd_a (
        .src_i      (Aa),
        .use_i      (use_a_d),
        .sb_e_i     (e_q),
        .sb_m_i     (m_q),
        .sel_o      (fwd_a),
        .load_hit_o (ld_a)
    );

    fwd_select #(.REG_AW(REG_AW), .XZR_IDX(XZR_IDX)) u_fwd_b (
        .src_i      (Ab),
        .use_i      (use_b_d),
        .sb_e_i     (e_q),
        .sb_m_i     (m_q),
        .sel_o      (fwd_b),
        .load_hit_o (ld_b)
    );

    assign ForwardA = fwd_a;
    assign ForwardB = fwd_b;

    assign hazard   = valid_d && (ld_a || ld_b);
    assign ld_stall = hazard && (state_q == HZ_RUN);

    // Memory busy overrides everything: freeze, never squash.
    assign StallF = mem_busy || ld_stall;
    assign StallD = mem_busy || ld_stall;
    assign FlushE = ld_stall && !mem_busy;
    // A branch depending on a load resolves only after the bubble.
    assign FlushD = BrTakenD && valid_d && !hazard && !mem_busy;

    always_comb begin
        e_d = SB_BUBBLE;
        if (valid_d && !FlushE) begin
            e_d.valid    = 1'b1;
            e_d.rd       = SB_RD_W'(RdD);
            e_d.regwrite = RegWriteD;
            e_d.memread  = MemReadD;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HZ_RUN:      if (ld_stall) state_d = HZ_LD_STALL;
            HZ_LD_STALL: state_d = HZ_RUN;
            default:     state_d = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q     <= SB_BUBBLE;
            m_q     <= SB_BUBBLE;
            state_q <= HZ_RUN;
        end else if (!mem_busy) begin
            e_q     <= e_d;
            m_q     <= e_q;
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!mem_busy) begin
            if (ld_stall) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (FlushD)   flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios
// plus randomized traffic against an instruction-history model.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_d;
    logic [4:0] Aa, Ab, RdD;
    logic       use_a_d, use_b_d, RegWriteD, MemReadD, BrTakenD, mem_busy;
    logic [1:0] ForwardA, ForwardB;
    logic       StallF, StallD, FlushD, FlushE;

    int n_chk  = 0;
    int n_pass = 0;

    hazard_control_unit dut (
        .clk(clk), .reset(reset), .valid_d(valid_d),
        .Aa(Aa), .Ab(Ab), .use_a_d(use_a_d), .use_b_d(use_b_d),
        .RdD(RdD), .RegWriteD(RegWriteD), .MemReadD(MemReadD),
        .BrTakenD(BrTakenD), .mem_busy(mem_busy),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE)
    );

    always #5 clk = ~clk;

    // Model: history of instructions issued past ID, youngest first.
    typedef struct { bit v; int rd; bit rw; bit mr; } inst_t;
    inst_t hist[$];

    function automatic void m_reset();
        inst_t b = '{0, 0, 0, 0};
        hist.delete();
        hist.push_back(b);
        hist.push_back(b);
    endfunction

    // Youngest in-flight writer of src wins; age 0 = EX (1), age 1 = MEM (2).
    function automatic int m_fwd(int src, bit u);
        if (!u || src == 31) return 0;
        foreach (hist[i])
            if (hist[i].v && hist[i].rw && hist[i].rd == src) return i + 1;
        return 0;
    endfunction

    function automatic bit m_haz();
        inst_t e = hist[0];
        if (!valid_d || !e.v || !e.mr || e.rd == 31) return 0;
        return (use_a_d && int'(Aa) == e.rd) || (use_b_d && int'(Ab) == e.rd);
    endfunction

    task automatic step();
        inst_t nx = '{0, 0, 0, 0};
        if (!mem_busy) begin
            if (valid_d && !m_haz()) nx = '{1, int'(RdD), RegWriteD, MemReadD};
            hist.push_front(nx);
            void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, int a, int b, bit ua, bit ub,
                         int rd, bit rw, bit mr, bit br, bit busy);
        valid_d = v; Aa = 5'(a); Ab = 5'(b);
        use_a_d = ua; use_b_d = ub; RdD = 5'(rd);
        RegWriteD = rw; MemReadD = mr; BrTakenD = br; mem_busy = busy;
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        n_chk++; if ({ForwardA, ForwardB} !== 4'd0) $display("FAIL rst_fwd: got %b want 0000", {ForwardA, ForwardB}); else n_pass++;
        n_chk++; if ({StallF, StallD, FlushD, FlushE} !== 4'd0) $display("FAIL rst_ctl: got %b want 0000", {StallF, StallD, FlushD, FlushE}); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_fwd_e();
        apply_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step();
        drive(1, 1, 7, 1, 0, 8, 1, 0, 0, 0);
        n_chk++; if (ForwardA !== 2'd1) $display("FAIL fwd_e_A: got %0d want 1", ForwardA); else n_pass++;
        n_chk++; if (StallF !== 1'b0) $display("FAIL fwd_e_stall: got %b want 0", StallF); else n_pass++;
    endtask

    task automatic test_fwd_m();
        apply_reset();
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        step();
        drive(1, 5, 2, 1, 1, 10, 1, 0, 0, 0);
        n_chk++; if (ForwardB !== 2'd2) $display("FAIL fwd_m_B: got %0d want 2", ForwardB); else n_pass++;
        n_chk++; if (ForwardA !== 2'd0) $display("FAIL fwd_m_A: got %0d want 0", ForwardA); else n_pass++;
    endtask

    task automatic test_e_priority();
        apply_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step();
        drive(1, 3, 3, 1, 0, 11, 1, 0, 0, 0);
        n_chk++; if (ForwardA !== 2'd1) $display("FAIL prio_A: got %0d want 1", ForwardA); else n_pass++;
        n_chk++; if (ForwardB !== 2'd0) $display("FAIL prio_B_unused: got %0d want 0", ForwardB); else n_pass++;
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        step();
        drive(1, 4, 0, 1, 0, 5, 1, 0, 0, 0);
        n_chk++; if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL lu_stall: got %b want 111", {StallF, StallD, FlushE}); else n_pass++;
        n_chk++; if (FlushD !== 1'b0) $display("FAIL lu_flushd: got %b want 0", FlushD); else n_pass++;
        step();
        drive(1, 4, 5, 1, 1, 5, 1, 0, 0, 0);
        n_chk++; if (ForwardA !== 2'd2) $display("FAIL lu_fwdA: got %0d want 2", ForwardA); else n_pass++;
        n_chk++; if (ForwardB !== 2'd0) $display("FAIL lu_bubble: got %0d want 0", ForwardB); else n_pass++;
        n_chk++; if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL lu_one_cycle: got %b want 000", {StallF, StallD, FlushE}); else n_pass++;
        step();
        drive(1, 5, 0, 1, 0, 6, 0, 0, 0, 0);
        n_chk++; if (ForwardA !== 2'd1) $display("FAIL lu_after: got %0d want 1", ForwardA); else n_pass++;
    endtask

    task automatic test_xzr();
        apply_reset();
        drive(1, 0, 0, 0, 0, 31, 1, 1, 0, 0);
        step();
        drive(1, 31, 31, 1, 1, 31, 1, 0, 0, 0);
        n_chk++; if ({ForwardA, ForwardB} !== 4'd0) $display("FAIL xzr_fwd: got %b want 0000", {ForwardA, ForwardB}); else n_pass++;
        n_chk++; if ({StallF, FlushE} !== 2'b00) $display("FAIL xzr_stall: got %b want 00", {StallF, FlushE}); else n_pass++;
    endtask

    task automatic test_branch_busy();
        apply_reset();
        drive(1, 0, 0, 0, 0, 6, 1, 0, 1, 0);
        n_chk++; if (FlushD !== 1'b1) $display("FAIL br_flush: got %b want 1", FlushD); else n_pass++;
        step();
        drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        n_chk++; if (FlushD !== 1'b0) $display("FAIL br_clear: got %b want 0", FlushD); else n_pass++;
        step();
        drive(1, 6, 0, 1, 0, 7, 1, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            n_chk++; if ({StallF, StallD, FlushD, FlushE} !== 4'b1100) $display("FAIL busy_ctl%0d: got %b want 1100", k, {StallF, StallD, FlushD, FlushE}); else n_pass++;
            n_chk++; if (ForwardA !== 2'd1) $display("FAIL busy_fwd%0d: got %0d want 1", k, ForwardA); else n_pass++;
            step();
        end
        drive(1, 6, 0, 1, 0, 7, 1, 0, 0, 0);
        n_chk++; if (ForwardA !== 2'd1) $display("FAIL busy_held: got %0d want 1", ForwardA); else n_pass++;
        step();
        n_chk++; if (ForwardA !== 2'd2) $display("FAIL busy_resume: got %0d want 2", ForwardA); else n_pass++;
    endtask

    task automatic test_reset_in_stall();
        apply_reset();
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        step();
        drive(1, 4, 0, 1, 0, 5, 1, 0, 0, 0);
        step();
        drive(1, 4, 4, 1, 1, 5, 1, 0, 0, 0);
        reset = 1'b1;
        m_reset();
        #1;
        n_chk++; if ({ForwardA, ForwardB} !== 4'd0) $display("FAIL rst_stall_fwd: got %b want 0000", {ForwardA, ForwardB}); else n_pass++;
        n_chk++; if ({StallF, StallD, FlushD, FlushE} !== 4'd0) $display("FAIL rst_stall_ctl: got %b want 0000", {StallF, StallD, FlushD, FlushE}); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_random();
        int regs[5] = '{1, 2, 3, 4, 31};
        int fa, fb;
        bit hz, st, fd, fe;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 8,
                  regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
                  1'($urandom), 1'($urandom), regs[$urandom_range(0, 4)],
                  1'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            fa = m_fwd(int'(Aa), use_a_d);
            fb = m_fwd(int'(Ab), use_b_d);
            hz = m_haz();
            st = mem_busy || hz;
            fe = hz && !mem_busy;
            fd = BrTakenD && valid_d && !hz && !mem_busy;
            n_chk++; if (ForwardA !== 2'(fa)) $display("FAIL rnd_fwdA c%0d: got %0d want %0d", c, ForwardA, fa); else n_pass++;
            n_chk++; if (ForwardB !== 2'(fb)) $display("FAIL rnd_fwdB c%0d: got %0d want %0d", c, ForwardB, fb); else n_pass++;
            n_chk++; if ({StallF, StallD} !== {st, st}) $display("FAIL rnd_stall c%0d: got %b%b want %b", c, StallF, StallD, st); else n_pass++;
            n_chk++; if (FlushE !== fe) $display("FAIL rnd_flushE c%0d: got %b want %b", c, FlushE, fe); else n_pass++;
            n_chk++; if (FlushD !== fd) $display("FAIL rnd_flushD c%0d: got %b want %b", c, FlushD, fd); else n_pass++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        m_reset();
        test_reset();
        test_fwd_e();
        test_fwd_m();
        test_e_priority();
        test_load_use();
        test_xzr();
        test_branch_busy();
        test_reset_in_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
